// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flagged FIFO.
// Depth/width derivation and the registered status-flag bundle.
package fifo_pkg;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    localparam int ADDR_W_DEF = 4;
    localparam int PTR_W_DEF  = ADDR_W_DEF + 1;
    localparam int CNT_W_DEF  = ADDR_W_DEF + 1;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered or (FIFO_FWFT_EN)
// combinational read.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

`ifdef FIFO_FWFT_EN
    logic unused_rd;
    assign unused_rd = rd_en ^ rst;
    assign rd_data   = mem[rd_addr];
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end
`endif

endmodule

// File: rtl/fifo_flags.sv
// Single-clock FIFO with count, thresholds, sticky errors and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = fifo_depth(ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_en_in,
    output logic                  full_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  read_en_in,
    output logic                  empty_out,
    output logic [ADDR_WIDTH:0]   count_out,
    output logic                  almost_full_out,
    output logic                  almost_empty_out,
    output logic                  overflow_out,
    output logic                  underflow_out,
    input  logic                  flush_in,
    input  logic                  clear_err_in
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int PW    = ptr_width(ADDR_WIDTH);

    logic [PW-1:0] wr_ptr, rd_ptr, cnt, cnt_nxt;
    fifo_flags_t   flg, flg_nxt;
    logic          rd_ok, wr_ok, rd_acc, wr_acc;
    logic          ovf_set, udf_set;

    // Flush discards the cycle's requests without counting them as errors.
    always_comb begin
        rd_ok   = read_en_in && !flg.empty;
        wr_ok   = write_en_in && (!flg.full || rd_ok);
        rd_acc  = rd_ok && !flush_in;
        wr_acc  = wr_ok && !flush_in;
        ovf_set = write_en_in && !wr_ok && !flush_in;
        udf_set = read_en_in && flg.empty && !flush_in;
    end

    always_comb begin
        cnt_nxt = cnt + PW'(wr_acc) - PW'(rd_acc);
        if (flush_in)
            cnt_nxt = '0;
        flg_nxt              = flg;
        flg_nxt.full         = cnt_nxt == PW'(DEPTH);
        flg_nxt.empty        = cnt_nxt == '0;
        flg_nxt.almost_full  = int'(cnt_nxt) >= AF_THRESH;
        flg_nxt.almost_empty = int'(cnt_nxt) <= AE_THRESH;
        flg_nxt.overflow     = ovf_set || (flg.overflow && !clear_err_in);
        flg_nxt.underflow    = udf_set || (flg.underflow && !clear_err_in);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            flg    <= FLAGS_RST;
        end else begin
            wr_ptr <= flush_in ? '0 : wr_ptr + PW'(wr_acc);
            rd_ptr <= flush_in ? '0 : rd_ptr + PW'(rd_acc);
            cnt    <= cnt_nxt;
            flg    <= flg_nxt;
        end
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_acc),
        .wr_addr(wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data(data_in),
        .rd_en  (rd_acc),
        .rd_addr(rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data(data_out)
    );

    assign count_out        = cnt;
    assign full_out         = flg.full;
    assign empty_out        = flg.empty;
    assign almost_full_out  = flg.almost_full;
    assign almost_empty_out = flg.almost_empty;
    assign overflow_out     = flg.overflow;
    assign underflow_out    = flg.underflow;

endmodule

// File: tb/tb_fifo_flags.sv
// Directed self-checking bench for fifo_flags (DEPTH 16, AF 14, AE 2).
// Handles both standard and FIFO_FWFT_EN read timing.
module tb_fifo_flags;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       write_en_in;
    logic       full_out;
    logic [7:0] data_out;
    logic       read_en_in;
    logic       empty_out;
    logic [4:0] count_out;
    logic       almost_full_out;
    logic       almost_empty_out;
    logic       overflow_out;
    logic       underflow_out;
    logic       flush_in;
    logic       clear_err_in;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fifo_flags #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .AF_THRESH (14),
        .AE_THRESH (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .data_in         (data_in),
        .write_en_in     (write_en_in),
        .full_out        (full_out),
        .data_out        (data_out),
        .read_en_in      (read_en_in),
        .empty_out       (empty_out),
        .count_out       (count_out),
        .almost_full_out (almost_full_out),
        .almost_empty_out(almost_empty_out),
        .overflow_out    (overflow_out),
        .underflow_out   (underflow_out),
        .flush_in        (flush_in),
        .clear_err_in    (clear_err_in)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        data_in     = d;
        write_en_in = 1'b1;
        step();
        write_en_in = 1'b0;
    endtask

    // Pop one word and check it with the mode's read timing.
    task automatic pop_check(input logic [7:0] exp, input string nm);
`ifdef FIFO_FWFT_EN
        nvec++;
        if (data_out !== exp) begin
            nerr++;
            $display("FAIL %s: data_out=%h expected %h", nm, data_out, exp);
        end
        read_en_in = 1'b1;
        step();
        read_en_in = 1'b0;
`else
        read_en_in = 1'b1;
        step();
        read_en_in = 1'b0;
        nvec++;
        if (data_out !== exp) begin
            nerr++;
            $display("FAIL %s: data_out=%h expected %h", nm, data_out, exp);
        end
`endif
    endtask

    task automatic check_state(input string nm, input logic [4:0] cnt,
                               input logic emp, input logic ful,
                               input logic ae, input logic af,
                               input logic ovf, input logic udf);
        nvec++;
        if ({count_out, empty_out, full_out, almost_empty_out,
             almost_full_out, overflow_out, underflow_out} !==
            {cnt, emp, ful, ae, af, ovf, udf}) begin
            nerr++;
            $display("FAIL %s: cnt=%0d e=%b f=%b ae=%b af=%b ovf=%b udf=%b expected cnt=%0d e=%b f=%b ae=%b af=%b ovf=%b udf=%b",
                     nm, count_out, empty_out, full_out, almost_empty_out,
                     almost_full_out, overflow_out, underflow_out,
                     cnt, emp, ful, ae, af, ovf, udf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        check_state("reset_flags", 5'd0, 1, 0, 1, 0, 0, 0);
        nvec++;
        if (data_out !== 8'h00) begin
            nerr++;
            $display("FAIL reset_data: data_out=%h expected 00", data_out);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        push(8'hAA);
        check_state("single_push", 5'd1, 0, 0, 1, 0, 0, 0);
        pop_check(8'hAA, "single_pop_data");
        check_state("single_pop", 5'd0, 1, 0, 1, 0, 0, 0);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            check_state($sformatf("fill_%0d", i + 1), 5'(i + 1), 0,
                        (i + 1) == 16, (i + 1) <= 2, (i + 1) >= 14, 0, 0);
        end
        for (int i = 0; i < 16; i++)
            pop_check(8'(i), $sformatf("drain_%0d", i));
        check_state("drained", 5'd0, 1, 0, 1, 0, 0, 0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++)
            push(8'(i));
        push(8'h55);
        check_state("ovf_set", 5'd16, 0, 1, 0, 1, 1, 0);
        clear_err_in = 1'b1;
        step();
        clear_err_in = 1'b0;
        check_state("ovf_clear", 5'd16, 0, 1, 0, 1, 0, 0);
        clear_err_in = 1'b1;
        push(8'h56);
        clear_err_in = 1'b0;
        check_state("ovf_set_wins", 5'd16, 0, 1, 0, 1, 1, 0);
        clear_err_in = 1'b1;
        step();
        clear_err_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        data_in     = 8'h77;
        write_en_in = 1'b1;
        pop_check(8'h00, "rw_full_head");
        write_en_in = 1'b0;
        check_state("rw_full", 5'd16, 0, 1, 0, 1, 0, 0);
        for (int i = 1; i < 16; i++)
            pop_check(8'(i), $sformatf("rw_drain_%0d", i));
        pop_check(8'h77, "rw_last");
        check_state("rw_empty", 5'd0, 1, 0, 1, 0, 0, 0);
    endtask

    task automatic test_underflow();
        data_in     = 8'h33;
        write_en_in = 1'b1;
        read_en_in  = 1'b1;
        step();
        write_en_in = 1'b0;
        read_en_in  = 1'b0;
        check_state("udf_rw_empty", 5'd1, 0, 0, 1, 0, 0, 1);
        pop_check(8'h33, "udf_pop");
        clear_err_in = 1'b1;
        step();
        clear_err_in = 1'b0;
        check_state("udf_clear", 5'd0, 1, 0, 1, 0, 0, 0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++)
            push(8'h40 + 8'(i));
        check_state("pre_flush", 5'd5, 0, 0, 0, 0, 0, 0);
        flush_in    = 1'b1;
        write_en_in = 1'b1;
        read_en_in  = 1'b1;
        data_in     = 8'h99;
        step();
        flush_in    = 1'b0;
        write_en_in = 1'b0;
        read_en_in  = 1'b0;
        check_state("flush", 5'd0, 1, 0, 1, 0, 0, 0);
`ifndef FIFO_FWFT_EN
        nvec++;
        if (data_out !== 8'h33) begin
            nerr++;
            $display("FAIL flush_hold: data_out=%h expected 33", data_out);
        end
`endif
        push(8'h5A);
        pop_check(8'h5A, "post_flush_pop");
    endtask

    task automatic test_reset_mid();
        data_in     = 8'h11;
        write_en_in = 1'b1;
        step();
        step();
        step();
        check_state("pre_rst", 5'd3, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_state("rst_mid", 5'd0, 1, 0, 1, 0, 0, 0);
        nvec++;
        if (data_out !== 8'h00) begin
            nerr++;
            $display("FAIL rst_mid_data: data_out=%h expected 00", data_out);
        end
        write_en_in = 1'b0;
        step();
        rst = 1'b0;
        step();
        check_state("post_rst", 5'd0, 1, 0, 1, 0, 0, 0);
    endtask

    initial begin
        rst          = 1'b1;
        data_in      = '0;
        write_en_in  = 1'b0;
        read_en_in   = 1'b0;
        flush_in     = 1'b0;
        clear_err_in = 1'b0;
        #1;
        test_reset();
        test_single();
        test_fill();
        test_overflow();
        test_back_to_back();
        test_underflow();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
